// File: rtl/parking_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : parking_lane_arbiter
//  Purpose  : Shares one parking gate controller (PIN check + gate) between
//             two entry lanes. Grants lanes round-robin, forwards the granted
//             lane's arrival and PIN code, sequences open/pass/close and
//             keeps the lot occupancy count.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   system clock, rising edge
//    rst                 in   synchronous active-high reset
//    lane_req[1:0]       in   bit i = vehicle waiting at lane i (level)
//    lane_code0/1[15:0]  in   PIN typed at lane 0 / lane 1
//    lane_passed[1:0]    in   bit i = vehicle cleared gate of lane i (pulse)
//    exit_event          in   vehicle left through the exit (pulse)
//    ctl_open_gate       in   controller: gate opened
//    ctl_wrong_ping      in   controller: wrong code
//    ctl_close_gate      in   controller: gate closed
//    ctl_blocked_gate    in   controller: blocked after repeated bad codes
//    ctl_vehicle_arrival out  arrival forwarded to the controller
//    ctl_code[15:0]      out  code of the granted lane
//    ctl_vehicle_left    out  1-cycle pulse: granted vehicle passed
//    grant[1:0]          out  one-hot lane grant, 0 when idle
//    lot_full            out  occupancy == CAPACITY
//    occupancy           out  vehicles currently inside
//    blocked             out  arbiter parked in BLOCKED
//    timeout_err         out  1-cycle pulse on SERVE timeout
//  All outputs are registered.
// ============================================================================
module parking_lane_arbiter #(
  parameter int CAPACITY = 8,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       lane_req,
  input  logic [15:0]      lane_code0,
  input  logic [15:0]      lane_code1,
  input  logic [1:0]       lane_passed,
  input  logic             exit_event,
  input  logic             ctl_open_gate,
  input  logic             ctl_wrong_ping,
  input  logic             ctl_close_gate,
  input  logic             ctl_blocked_gate,
  output logic             ctl_vehicle_arrival,
  output logic [15:0]      ctl_code,
  output logic             ctl_vehicle_left,
  output logic [1:0]       grant,
  output logic             lot_full,
  output logic [CNT_W-1:0] occupancy,
  output logic             blocked,
  output logic             timeout_err
);

  // Timer only ever holds 0..TIMEOUT-1; +1 keeps the width sane for TIMEOUT=1.
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_serve   = 3'd1;
  localparam logic [2:0] c_st_blocked = 3'd2;
  localparam logic [2:0] c_st_pass    = 3'd3;
  localparam logic [2:0] c_st_close   = 3'd4;

  localparam logic [CNT_W-1:0] c_capacity = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State and registered datapath
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic             r_ptr;            // lane favoured on a simultaneous request
  logic             w_ptr_next;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_next;
  logic             r_arrival;
  logic             w_arrival_next;
  logic [15:0]      r_code;
  logic [15:0]      w_code_next;
  logic             r_left;
  logic             w_left_next;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] w_occ_next;
  logic             r_full;
  logic             w_full_next;
  logic             r_blocked;
  logic             w_blocked_next;
  logic             r_tmo;
  logic             w_tmo_next;

  logic [1:0]       w_pick;           // lane the arbiter would grant from IDLE
  logic             w_lane;           // index of the currently granted lane
  logic             w_lane_next;      // index of the lane granted next cycle
  logic             w_timeout;        // SERVE gave up waiting this cycle
  logic             w_exit_ok;        // exit that may actually decrement

  assign w_lane = r_grant[1];

  // Round-robin pick: a lone requester always wins; on a tie the pointer
  // decides.
  always_comb begin
    w_pick = 2'b00;
    if (lane_req == 2'b11) begin
      w_pick = r_ptr ? 2'b10 : 2'b01;
    end else begin
      w_pick = lane_req;
    end
  end

  // A response from the controller (or a wrong PIN, which restarts the
  // timer) pre-empts the timeout in the same cycle.
  assign w_timeout = (r_state == c_st_serve) && !ctl_open_gate &&
                     !ctl_blocked_gate && !ctl_wrong_ping &&
                     (r_timer == c_tmr_last);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (!r_full && (lane_req != 2'b00)) begin
          w_state_next = c_st_serve;
        end
      end
      c_st_serve: begin
        // open_gate wins over blocked_gate in the same cycle
        if (ctl_open_gate) begin
          w_state_next = c_st_pass;
        end else if (ctl_blocked_gate) begin
          w_state_next = c_st_blocked;
        end else if (w_timeout) begin
          w_state_next = c_st_idle;
        end
      end
      c_st_blocked: begin
        if (ctl_open_gate) begin
          w_state_next = c_st_pass;
        end
      end
      c_st_pass: begin
        if (lane_passed[w_lane]) begin
          w_state_next = c_st_close;
        end
      end
      c_st_close: begin
        if (ctl_close_gate) begin
          w_state_next = c_st_idle;
        end
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    w_timer_next = r_timer;
    w_lane_next  = w_lane;

    case (r_state)
      c_st_idle: begin
        w_timer_next = '0;
        if (w_state_next == c_st_serve) begin
          w_grant_next = w_pick;
          // pointer moves to the lane that was not granted
          w_ptr_next   = w_pick[0];
          w_lane_next  = w_pick[1];
        end else begin
          w_grant_next = 2'b00;
        end
      end
      c_st_serve: begin
        if (ctl_wrong_ping || w_timeout) begin
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      c_st_blocked: begin
        // timer frozen while the controller has the lane blocked
        w_timer_next = r_timer;
      end
      default: begin
        w_timer_next = '0;
      end
    endcase

    if ((r_state != c_st_idle) && (w_state_next == c_st_idle)) begin
      w_grant_next = 2'b00;
    end

    w_arrival_next = (w_state_next == c_st_serve) ||
                     (w_state_next == c_st_blocked);

    // Code follows the keypad live while the arrival is forwarded.
    if (w_arrival_next) begin
      w_code_next = w_lane_next ? lane_code1 : lane_code0;
    end else begin
      w_code_next = r_code;
    end

    w_left_next    = (r_state == c_st_pass) && lane_passed[w_lane];
    w_blocked_next = (w_state_next == c_st_blocked);
    w_tmo_next     = w_timeout;
  end

  // --------------------------------------------------------------------------
  // Occupancy: the increment lands in the same cycle ctl_vehicle_left pulses.
  // An entry and an exit together cancel; an exit from an empty lot is noise.
  // --------------------------------------------------------------------------
  assign w_exit_ok = exit_event && (r_occ != '0);

  always_comb begin
    w_occ_next = r_occ;
    if (w_left_next && !exit_event) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_left_next && w_exit_ok) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  // lot_full derived from the next count so it tracks occupancy exactly
  assign w_full_next = (w_occ_next == c_capacity);

  // --------------------------------------------------------------------------
  // Registered datapath and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_timer   <= '0;
      r_grant   <= 2'b00;
      r_arrival <= 1'b0;
      r_code    <= 16'h0000;
      r_left    <= 1'b0;
      r_occ     <= '0;
      r_full    <= 1'b0;
      r_blocked <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_next;
      r_timer   <= w_timer_next;
      r_grant   <= w_grant_next;
      r_arrival <= w_arrival_next;
      r_code    <= w_code_next;
      r_left    <= w_left_next;
      r_occ     <= w_occ_next;
      r_full    <= w_full_next;
      r_blocked <= w_blocked_next;
      r_tmo     <= w_tmo_next;
    end
  end

  assign ctl_vehicle_arrival = r_arrival;
  assign ctl_code            = r_code;
  assign ctl_vehicle_left    = r_left;
  assign grant               = r_grant;
  assign lot_full            = r_full;
  assign occupancy           = r_occ;
  assign blocked             = r_blocked;
  assign timeout_err         = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_parking_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parking_lane_arbiter
//  Purpose  : Self-checking bench for parking_lane_arbiter. Expected grants,
//             occupancy-on-entry and timeout cycles are queued as stimulus is
//             driven and compared when the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parking_lane_arbiter;

  localparam int CAPACITY = 8;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 32;

  logic             clk;
  logic             rst;
  logic [1:0]       lane_req;
  logic [15:0]      lane_code0;
  logic [15:0]      lane_code1;
  logic [1:0]       lane_passed;
  logic             exit_event;
  logic             ctl_open_gate;
  logic             ctl_wrong_ping;
  logic             ctl_close_gate;
  logic             ctl_blocked_gate;
  logic             ctl_vehicle_arrival;
  logic [15:0]      ctl_code;
  logic             ctl_vehicle_left;
  logic [1:0]       grant;
  logic             lot_full;
  logic [CNT_W-1:0] occupancy;
  logic             blocked;
  logic             timeout_err;

  parking_lane_arbiter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lane_req            (lane_req),
    .lane_code0          (lane_code0),
    .lane_code1          (lane_code1),
    .lane_passed         (lane_passed),
    .exit_event          (exit_event),
    .ctl_open_gate       (ctl_open_gate),
    .ctl_wrong_ping      (ctl_wrong_ping),
    .ctl_close_gate      (ctl_close_gate),
    .ctl_blocked_gate    (ctl_blocked_gate),
    .ctl_vehicle_arrival (ctl_vehicle_arrival),
    .ctl_code            (ctl_code),
    .ctl_vehicle_left    (ctl_vehicle_left),
    .grant               (grant),
    .lot_full            (lot_full),
    .occupancy           (occupancy),
    .blocked             (blocked),
    .timeout_err         (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         m_occ = 0;
  int         exp_occ;
  bit         tmo_seen = 0;
  logic [1:0] prev_grant = 2'b00;

  logic [1:0] q_grant[$];
  int         q_occ[$];
  int         q_tmo[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: compare DUT events against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if ((grant !== prev_grant) && (grant != 2'b00)) begin
        if (q_grant.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
        else check("grant_seq", 32'(grant), 32'(q_grant.pop_front()));
      end
      if (ctl_vehicle_left) begin
        if (q_occ.size() == 0) begin
          check("left_unexpected", 32'(ctl_vehicle_left), 32'd0);
        end else begin
          exp_occ = q_occ.pop_front();
          check("occ_on_left", 32'(occupancy), 32'(exp_occ));
          check("full_on_left", 32'(lot_full), 32'(exp_occ == CAPACITY));
        end
      end
      if (timeout_err) begin
        tmo_seen = 1;
        if (q_tmo.size() == 0) begin
          check("tmo_unexpected", 32'(timeout_err), 32'd0);
        end else begin
          check("tmo_cycle", 32'(cyc), 32'(q_tmo.pop_front()));
          check("tmo_grant", 32'(grant), 32'd0);
        end
      end
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] exp_g, input logic [15:0] exp_code);
    bit seen = 0;
    q_grant.push_back(exp_g);
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (grant != 2'b00) seen = 1;
    end
    check("grant_seen", 32'(seen), 32'd1);
    check("arrival_serve", 32'(ctl_vehicle_arrival), 32'd1);
    check("code_serve", 32'(ctl_code), 32'(exp_code));
  endtask

  task automatic do_open(input logic [1:0] g);
    ctl_open_gate = 1'b1;
    tick();
    ctl_open_gate = 1'b0;
    check("arrival_pass", 32'(ctl_vehicle_arrival), 32'd0);
    check("blocked_pass", 32'(blocked), 32'd0);
    check("grant_pass", 32'(grant), 32'(g));
  endtask

  task automatic do_leave(input logic [1:0] g, input bit exit_same);
    if (!exit_same) m_occ++;
    q_occ.push_back(m_occ);
    lane_passed = g;
    exit_event  = exit_same;
    tick();
    lane_passed = 2'b00;
    exit_event  = 1'b0;
    check("left_pulse", 32'(ctl_vehicle_left), 32'd1);
    tick();
    check("left_once", 32'(ctl_vehicle_left), 32'd0);
    check("grant_close", 32'(grant), 32'(g));
    ctl_close_gate = 1'b1;
    tick();
    ctl_close_gate = 1'b0;
    check("grant_idle", 32'(grant), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    lane_req         = 2'b11;
    lane_code0       = 16'hC159;
    lane_code1       = 16'hBEEF;
    lane_passed      = 2'b00;
    exit_event       = 1'b0;
    ctl_open_gate    = 1'b0;
    ctl_wrong_ping   = 1'b0;
    ctl_close_gate   = 1'b0;
    ctl_blocked_gate = 1'b0;

    // ---- reset held two cycles with both lanes requesting
    tick();
    tick();
    check("rst_arrival", 32'(ctl_vehicle_arrival), 32'd0);
    check("rst_code", 32'(ctl_code), 32'd0);
    check("rst_left", 32'(ctl_vehicle_left), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_full", 32'(lot_full), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_blocked", 32'(blocked), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // ---- first grant after reset goes to lane 0; lane 0 happy path
    wait_grant(2'b01, 16'hC159);
    lane_req = 2'b01;
    do_open(2'b01);
    do_leave(2'b01, 1'b0);
    lane_req = 2'b00;
    check("occ_after_first", 32'(occupancy), 32'd1);

    // ---- timeout on lane 1 (request dropped does not abort)
    lane_req = 2'b10;
    wait_grant(2'b10, 16'hBEEF);
    q_tmo.push_back(cyc + TIMEOUT);
    lane_req = 2'b00;
    tmo_seen = 0;
    for (int i = 0; i < TIMEOUT + 8 && !tmo_seen; i++) tick();
    check("tmo_seen", 32'(tmo_seen), 32'd1);
    check("tmo_grant_after", 32'(grant), 32'd0);
    check("tmo_arrival_after", 32'(ctl_vehicle_arrival), 32'd0);
    check("tmo_occ", 32'(occupancy), 32'(m_occ));
    tick();
    check("tmo_pulse_width", 32'(timeout_err), 32'd0);

    // ---- fairness: both lanes requesting over four full cycles
    lane_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        wait_grant(2'b01, 16'hC159);
        do_open(2'b01);
        do_leave(2'b01, 1'b0);
      end else begin
        wait_grant(2'b10, 16'hBEEF);
        do_open(2'b10);
        do_leave(2'b10, 1'b0);
      end
    end
    lane_req = 2'b00;
    check("occ_fair", 32'(occupancy), 32'd5);

    // ---- wrong PIN twice, then blocked; no timeout while blocked
    lane_req = 2'b01;
    wait_grant(2'b01, 16'hC159);
    for (int i = 0; i < 2; i++) begin
      ctl_wrong_ping = 1'b1;
      tick();
      ctl_wrong_ping = 1'b0;
      check("wrong_stays_serve", 32'(ctl_vehicle_arrival), 32'd1);
      check("wrong_not_blocked", 32'(blocked), 32'd0);
      for (int j = 0; j < TIMEOUT - 4; j++) tick();
    end
    ctl_blocked_gate = 1'b1;
    tick();
    ctl_blocked_gate = 1'b0;
    check("blocked_set", 32'(blocked), 32'd1);
    check("blocked_arrival", 32'(ctl_vehicle_arrival), 32'd1);
    lane_req   = 2'b11;
    lane_code0 = 16'h1234;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("blocked_grant_hold", 32'(grant), 32'h1);
      check("blocked_hold", 32'(blocked), 32'd1);
    end
    check("blocked_code_live", 32'(ctl_code), 32'h1234);
    lane_req   = 2'b00;
    lane_code0 = 16'hC159;
    do_open(2'b01);
    lane_passed = 2'b10;
    tick();
    lane_passed = 2'b00;
    check("wrong_lane_passed", 32'(ctl_vehicle_left), 32'd0);
    do_leave(2'b01, 1'b0);

    // ---- fill to capacity, with a cancelling exit at occupancy 7
    lane_req = 2'b01;
    wait_grant(2'b01, 16'hC159);
    do_open(2'b01);
    do_leave(2'b01, 1'b0);
    check("occ_seven", 32'(occupancy), 32'd7);
    wait_grant(2'b01, 16'hC159);
    do_open(2'b01);
    do_leave(2'b01, 1'b1);
    check("occ_cancel", 32'(occupancy), 32'd7);
    wait_grant(2'b01, 16'hC159);
    do_open(2'b01);
    do_leave(2'b01, 1'b0);
    check("full_set", 32'(lot_full), 32'd1);
    check("occ_full", 32'(occupancy), 32'(CAPACITY));
    lane_req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("full_no_grant", 32'(grant), 32'd0);
    end
    lane_req = 2'b00;
    tick();

    // ---- drain the lot, then an exit from empty
    for (int i = 0; i < CAPACITY; i++) begin
      exit_event = 1'b1;
      tick();
      exit_event = 1'b0;
      m_occ--;
      check("occ_drain", 32'(occupancy), 32'(m_occ));
      check("full_drain", 32'(lot_full), 32'd0);
    end
    exit_event = 1'b1;
    tick();
    exit_event = 1'b0;
    check("exit_at_zero", 32'(occupancy), 32'd0);
    tick();
    check("exit_at_zero_hold", 32'(occupancy), 32'd0);

    check("q_grant_empty", 32'(q_grant.size()), 32'd0);
    check("q_occ_empty", 32'(q_occ.size()), 32'd0);
    check("q_tmo_empty", 32'(q_tmo.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
